// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcodes, sequencer states and instruction-class helper
package cpu_defs_pkg;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_SHR  = 5'b01001;
    localparam logic [4:0] OPC_SHRA = 5'b01010;
    localparam logic [4:0] OPC_SHL  = 5'b01011;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11001;
    localparam logic [4:0] OPC_HALT = 5'b11010;
    localparam logic [4:0] OPC_INC  = 5'b11111;
    localparam logic [4:0] OPC_IDLE = 5'b00000;

    typedef enum logic [3:0] {
        S_RESET, T0, T1, T2, T3, T4, T5, T6, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_BINARY, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT
    } op_class_e;

    typedef struct packed {
        logic [4:0] opcode;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } ir_fields_t;

    function automatic op_class_e classify(input logic [4:0] opc);
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL: return CLS_BINARY;
            OPC_MUL, OPC_DIV:                    return CLS_MULDIV;
            OPC_NEG, OPC_NOT:                    return CLS_UNARY;
            OPC_HALT:                            return CLS_HALT;
            default:                             return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/reg_select.sv
// rtl/reg_select.sv - 4-bit register field plus enable to 16-bit one-hot select
module reg_select (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore fetch/decode/execute control sequencer
module control_sequencer
    import cpu_defs_pkg::*;
#(
    parameter logic [4:0] OP_INC        = OPC_INC,
    parameter int         RESET_PC_HOLD = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        ZlowIn,
    output logic        ZhighIn,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  alu_op,
    output logic        run
);

    localparam int CNT_W = (RESET_PC_HOLD > 0) ? $clog2(RESET_PC_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(RESET_PC_HOLD);

    state_e           state_q, state_d;
    ir_fields_t       ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       rin_en, rout_en;
    logic [3:0] rin_sel, rout_sel;
    op_class_e  cls;

    // Only the opcode and register fields steer the sequence.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[14:0];

    assign cls = classify(ir_q.opcode);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RESET;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET: begin
                if (cnt_q == HOLD_CNT) begin
                    state_d = T0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            T0: state_d = T1;
            T1: state_d = T2;
            T2: begin
                // IR is loaded by the datapath on this same edge, so capture the live input.
                state_d = T3;
                ir_d    = IR[31:15];
            end
            T3: begin
                case (cls)
                    CLS_BINARY, CLS_MULDIV, CLS_UNARY: state_d = T4;
                    CLS_HALT:                          state_d = S_HALT;
                    default:                           state_d = T0;
                endcase
            end
            T4: state_d = (cls == CLS_UNARY) ? T0 : T5;
            T5: state_d = (cls == CLS_MULDIV) ? T6 : T0;
            T6: state_d = T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        ZlowIn   = 1'b0;
        ZhighIn  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = OPC_IDLE;
        rin_en   = 1'b0;
        rin_sel  = 4'd0;
        rout_en  = 1'b0;
        rout_sel = 4'd0;
        run      = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                ZlowIn = 1'b1;
                alu_op = OP_INC;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                case (cls)
                    CLS_BINARY: begin
                        rout_en  = 1'b1;
                        rout_sel = ir_q.rb;
                        Yin      = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ir_q.ra;
                        Yin      = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_en  = 1'b1;
                        rout_sel = ir_q.rb;
                        alu_op   = ir_q.opcode;
                        ZlowIn   = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_BINARY: begin
                        rout_en  = 1'b1;
                        rout_sel = ir_q.rc;
                        alu_op   = ir_q.opcode;
                        ZlowIn   = 1'b1;
                    end
                    CLS_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ir_q.rb;
                        alu_op   = ir_q.opcode;
                        ZlowIn   = 1'b1;
                        ZhighIn  = 1'b1;
                    end
                    CLS_UNARY: begin
                        Zlowout = 1'b1;
                        rin_en  = 1'b1;
                        rin_sel = ir_q.ra;
                    end
                    default: ;
                endcase
            end
            T5: begin
                Zlowout = 1'b1;
                if (cls == CLS_MULDIV) begin
                    LOin = 1'b1;
                end else begin
                    rin_en  = 1'b1;
                    rin_sel = ir_q.ra;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select u_rin_sel (
        .sel    (rin_sel),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_select u_rout_sel (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - vector table, reference model and corner sequences for control_sequencer
module tb_control_sequencer;

    localparam int HOLD = 1;

    typedef struct packed {
        logic [13:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        run;
    } outv_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [2:0]  n;
        outv_t [3:0] e;
    } vec_t;

    localparam logic [13:0] M_PCOUT    = 14'(1) << 13;
    localparam logic [13:0] M_MARIN    = 14'(1) << 12;
    localparam logic [13:0] M_PCIN     = 14'(1) << 11;
    localparam logic [13:0] M_READ     = 14'(1) << 10;
    localparam logic [13:0] M_MDRIN    = 14'(1) << 9;
    localparam logic [13:0] M_MDROUT   = 14'(1) << 8;
    localparam logic [13:0] M_IRIN     = 14'(1) << 7;
    localparam logic [13:0] M_YIN      = 14'(1) << 6;
    localparam logic [13:0] M_ZLOWOUT  = 14'(1) << 5;
    localparam logic [13:0] M_ZHIGHOUT = 14'(1) << 4;
    localparam logic [13:0] M_ZLOWIN   = 14'(1) << 3;
    localparam logic [13:0] M_ZHIGHIN  = 14'(1) << 2;
    localparam logic [13:0] M_HIIN     = 14'(1) << 1;
    localparam logic [13:0] M_LOIN     = 14'(1) << 0;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'h0;
    logic PCout, MARin, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Zlowout, Zhighout, ZlowIn, ZhighIn, HIin, LOin, run;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    outv_t act;

    int total = 0;
    int bad = 0;
    outv_t exp_q[$];
    vec_t  vecs[5];

    control_sequencer #(.OP_INC(5'b11111), .RESET_PC_HOLD(HOLD)) dut (
        .clock(clock), .clear(clear), .IR(IR),
        .PCout(PCout), .MARin(MARin), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .ZlowIn(ZlowIn), .ZhighIn(ZhighIn),
        .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run)
    );

    always #5 clock = ~clock;

    always_comb act = {PCout, MARin, PCin, Read, MDRin, MDRout, IRin, Yin,
                       Zlowout, Zhighout, ZlowIn, ZhighIn, HIin, LOin,
                       Rin, Rout, alu_op, run};

    function automatic outv_t ov(input logic [13:0] s, input logic [15:0] ri,
                                 input logic [15:0] ro, input logic [4:0] a);
        outv_t r;
        r.strb = s;
        r.rin  = ri;
        r.rout = ro;
        r.alu  = a;
        r.run  = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] n);
        return 16'(1) << n;
    endfunction

    task automatic check(input string name, input outv_t got, input outv_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got strb=%b rin=%h rout=%h alu=%b run=%b, want strb=%b rin=%h rout=%h alu=%b run=%b",
                     name, got.strb, got.rin, got.rout, got.alu, got.run,
                     want.strb, want.rin, want.rout, want.alu, want.run);
        end
    endtask

    task automatic push_fetch();
        exp_q.push_back(ov(M_PCOUT | M_MARIN | M_ZLOWIN, 16'h0, 16'h0, 5'b11111));
        exp_q.push_back(ov(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 16'h0, 16'h0, 5'b0));
        exp_q.push_back(ov(M_MDROUT | M_IRIN, 16'h0, 16'h0, 5'b0));
    endtask

    // Reference: per-instruction cycle list derived from the opcode class rules.
    task automatic build_expect(input logic [31:0] ir);
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        opc = ir[31:27];
        ra  = ir[26:23];
        rb  = ir[22:19];
        rc  = ir[18:15];
        exp_q.delete();
        push_fetch();
        if (opc inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11}) begin
            exp_q.push_back(ov(M_YIN, 16'h0, oh(rb), 5'b0));
            exp_q.push_back(ov(M_ZLOWIN, 16'h0, oh(rc), opc));
            exp_q.push_back(ov(M_ZLOWOUT, oh(ra), 16'h0, 5'b0));
        end else if (opc inside {5'd15, 5'd16}) begin
            exp_q.push_back(ov(M_YIN, 16'h0, oh(ra), 5'b0));
            exp_q.push_back(ov(M_ZLOWIN | M_ZHIGHIN, 16'h0, oh(rb), opc));
            exp_q.push_back(ov(M_ZLOWOUT | M_LOIN, 16'h0, 16'h0, 5'b0));
            exp_q.push_back(ov(M_ZHIGHOUT | M_HIIN, 16'h0, 16'h0, 5'b0));
        end else if (opc inside {5'd17, 5'd18}) begin
            exp_q.push_back(ov(M_ZLOWIN, 16'h0, oh(rb), opc));
            exp_q.push_back(ov(M_ZLOWOUT, oh(ra), 16'h0, 5'b0));
        end else begin
            exp_q.push_back(ov(14'h0, 16'h0, 16'h0, 5'b0));
        end
    endtask

    // IR carries the instruction only during T2; other cycles see noise.
    task automatic apply(input string tag, input logic [31:0] ir);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s_c%0d", tag, i), act, exp_q[i]);
            IR = (i == 2) ? ir : $urandom;
        end
    endtask

    task automatic release_reset(input string tag);
        clear = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s_hold%0d", tag, i), act, '0);
        end
    endtask

    initial begin
        logic [4:0]  pick[16];
        logic [31:0] ir;

        pick = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                 5'd15, 5'd16, 5'd17, 5'd18, 5'd25, 5'd12, 5'd31};

        vecs[0].ir = 32'h2A1B8000; vecs[0].n = 3;
        vecs[0].e[0] = ov(M_YIN, 16'h0, 16'h0008, 5'b0);
        vecs[0].e[1] = ov(M_ZLOWIN, 16'h0, 16'h0080, 5'b00101);
        vecs[0].e[2] = ov(M_ZLOWOUT, 16'h0010, 16'h0, 5'b0);
        vecs[0].e[3] = '0;
        vecs[1].ir = 32'h321B8000; vecs[1].n = 3;
        vecs[1].e[0] = ov(M_YIN, 16'h0, 16'h0008, 5'b0);
        vecs[1].e[1] = ov(M_ZLOWIN, 16'h0, 16'h0080, 5'b00110);
        vecs[1].e[2] = ov(M_ZLOWOUT, 16'h0010, 16'h0, 5'b0);
        vecs[1].e[3] = '0;
        vecs[2].ir = 32'h7A180000; vecs[2].n = 4;
        vecs[2].e[0] = ov(M_YIN, 16'h0, 16'h0010, 5'b0);
        vecs[2].e[1] = ov(M_ZLOWIN | M_ZHIGHIN, 16'h0, 16'h0008, 5'b01111);
        vecs[2].e[2] = ov(M_ZLOWOUT | M_LOIN, 16'h0, 16'h0, 5'b0);
        vecs[2].e[3] = ov(M_ZHIGHOUT | M_HIIN, 16'h0, 16'h0, 5'b0);
        vecs[3].ir = 32'h8A180000; vecs[3].n = 2;
        vecs[3].e[0] = ov(M_ZLOWIN, 16'h0, 16'h0008, 5'b10001);
        vecs[3].e[1] = ov(M_ZLOWOUT, 16'h0010, 16'h0, 5'b0);
        vecs[3].e[2] = '0;
        vecs[3].e[3] = '0;
        vecs[4].ir = 32'hC8000000; vecs[4].n = 1;
        vecs[4].e[0] = ov(14'h0, 16'h0, 16'h0, 5'b0);
        vecs[4].e[1] = '0;
        vecs[4].e[2] = '0;
        vecs[4].e[3] = '0;

        clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", act, '0);
        release_reset("rst");

        for (int v = 0; v < 5; v++) begin
            exp_q.delete();
            push_fetch();
            for (int j = 0; j < int'(vecs[v].n); j++) exp_q.push_back(vecs[v].e[j]);
            apply($sformatf("vec%0d", v), vecs[v].ir);
        end

        for (int k = 0; k < 40; k++) begin
            ir = $urandom;
            ir[31:27] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : pick[$urandom_range(0, 15)];
            if (ir[31:27] == 5'b11010) ir[31:27] = 5'b11001;
            build_expect(ir);
            apply($sformatf("rnd%0d", k), ir);
        end

        // Clear lands inside T4 of an add: strobes drop before the next edge, no Rin write.
        ir = 32'h1A1B8000;
        build_expect(ir);
        exp_q = exp_q[0:3];
        apply("midclr", ir);
        @(posedge clock);
        #1;
        check("midclr_t4", act, ov(M_ZLOWIN, 16'h0, 16'h0080, 5'b00011));
        #2;
        clear = 1'b1;
        #1;
        check("midclr_async", act, '0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("midclr_held%0d", i), act, '0);
        end
        release_reset("midclr");
        build_expect(32'h2A1B8000);
        apply("after_midclr", 32'h2A1B8000);

        build_expect(32'hD0000000);
        apply("halt", 32'hD0000000);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            IR = $urandom;
            check($sformatf("halt_idle%0d", i), act, '0);
        end
        #2;
        clear = 1'b1;
        #1;
        check("halt_clr", act, '0);
        @(posedge clock);
        #1;
        release_reset("halt");
        build_expect(32'h8A180000);
        apply("restart", 32'h8A180000);
        build_expect(32'h321B8000);
        apply("restart2", 32'h321B8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OP_INC, default 5'b11111, ALU opcode for PC increment.
REQ-002 SHALL have parameter RESET_PC_HOLD, default 1, cycles spent in S_RESET after clear deasserts before the first fetch.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clear  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port IR  in  32  instruction register contents: [31:27] opcode, [26:23] ra, [22:19] rb, [18:15] rc.
REQ-006 SHALL have outputs PCout, MARin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, ZlowIn, ZhighIn, HIin, LOin  out  1 each  datapath strobes.
REQ-007 SHALL have outputs Rin, Rout  out  16 each  one-hot register write and drive enables; bit n maps to Rn.
REQ-008 SHALL have output alu_op  out  5  ALU opcode to datapath; 5'b00000 when idle.
REQ-009 SHALL have output run  out  1  high while sequencing, low in S_HALT.

Function
REQ-010 SHALL be a Moore FSM with states S_RESET, T0, T1, T2, T3, T4, T5, T6, S_HALT; outputs decode from state and latched IR fields only.
REQ-011 Fetch: T0 SHALL assert PCout, MARin, ZlowIn, alu_op=OP_INC. T1 SHALL assert Zlowout, PCin, Read, MDRin. T2 SHALL assert MDRout, IRin.
REQ-012 At the T2->T3 edge, the FSM SHALL sample IR from the input. Decode SHALL use the IR value presented during T2, because IRin loads on that edge.
REQ-013 Binary ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
- T3: Rout[rb], Yin.
- T4: Rout[rc], alu_op=opcode, ZlowIn.
- T5: Zlowout, Rin[ra].
- Then T0.
REQ-014 mul 01111 / div 10000:
- T3: Rout[ra], Yin.
- T4: Rout[rb], alu_op=opcode, ZlowIn, ZhighIn.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
- Then T0.
REQ-015 Unary ops (neg 10001, not 10010):
- T3: Rout[rb], alu_op=opcode, ZlowIn.
- T4: Zlowout, Rin[ra].
- Then T0.
REQ-016 nop 11001 and any unlisted opcode SHALL return T3->T0 with no strobes asserted in T3.
REQ-017 halt 11010 SHALL go T3->S_HALT. S_HALT SHALL hold with all strobes 0 and run=0 until clear.
REQ-018 At most one Rout bit SHALL be high in any cycle; the same holds for Rin.
REQ-019 In every state, strobes not listed for that state SHALL be 0.
REQ-020 Each instruction SHALL take exactly 3 fetch cycles plus execute: binary 3, mul/div 4, unary 2, nop 1.

Reset
REQ-021 While clear=1, state SHALL be S_RESET, all strobes 0, Rin=Rout=0, alu_op=0, run=0.
REQ-022 After clear falls, the FSM SHALL stay in S_RESET for RESET_PC_HOLD rising edges, then enter T0 with run=1.
REQ-023 Asserting clear mid-instruction (any Tn) SHALL force S_RESET and drop all strobes immediately, without waiting for a clock edge.

Structure
REQ-024 Instruction opcodes, OP_INC and state encodings SHALL live in a shared package (cpu_defs_pkg) also used by the ALU.
REQ-025 A sub-module reg_select SHALL decode a 4-bit field plus enable into a 16-bit one-hot vector. It SHALL be instantiated twice: once for Rin, once for Rout.

Verification
REQ-026 Reset, then present IR=32'h2A1B8000 at T2 (and r4,r3,r7):
- T3 Rout=16'h0008, Yin=1.
- T4 Rout=16'h0080, alu_op=00101, ZlowIn=1.
- T5 Rin=16'h0010, Zlowout=1.
- Then T0.
REQ-027 IR=32'h321B8000 (or r4,r3,r7): same sequence as REQ-026 but alu_op=00110 in T4.
REQ-028 IR=32'h7A180000 (mul r4,r3):
- T3 Rout=16'h0010.
- T4 Rout=16'h0008, ZlowIn=ZhighIn=1, alu_op=01111.
- T5 LOin=1.
- T6 HIin=1.
REQ-029 IR=32'h8A180000 (neg r4,r3):
- T3 Rout=16'h0008, alu_op=10001.
- T4 Rin=16'h0010.
- Next cycle T0 with PCout=1, alu_op=11111.
REQ-030 IR=32'hD0000000 (halt): run falls on the cycle after T3 and stays 0 for 20 cycles; a following clear pulse restarts at T0.
REQ-031 Assert clear during T4 of an add: all strobes are 0 before the next edge, and no Rin pulse occurs.
